// File: rtl/mac_dot_engine.sv
// mac_dot_engine: consumer stage behind the SDRAM reader.
// The image words are captured into a local buffer. The weight stream is then
// multiply-accumulated against the buffer, one byte lane group per cycle, and
// one signed dot product is emitted per neuron.
// Optional build macro: MAC_DOT_ENGINE_RELU_EN. When it is defined, a negative
// final neuron sum is reported as 0 in result.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for the first image word
// LOAD_IMG  | storing image words, acknowledging each with next_img
// ARM       | one cycle that pulses mac_start to open the weight stream
// WAIT_WORD | waiting for a weight word (or all_done)
// COMPUTE   | LANES_PER_CYCLE products per cycle into the accumulator
// RESPOND   | mac_done (and result) visible, then back to WAIT_WORD
// FINISH    | terminal; only reset leaves
module mac_dot_engine #(
  parameter int DATA_W          = 128,
  parameter int IMG_WORDS       = 49,
  parameter int LANES_PER_CYCLE = 4,
  parameter int ACC_W           = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    img_word_valid,
  input  logic                    img_load_done,
  input  logic                    wt_word_valid,
  input  logic                    all_done,
  output logic                    next_img,
  output logic                    mac_start,
  output logic                    mac_done,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  output logic [15:0]             result_index,
  output logic                    img_overflow,
  output logic                    busy
);

  localparam int LANES   = DATA_W / 8;
  localparam int GROUPS  = LANES / LANES_PER_CYCLE;
  localparam int PTR_W   = $clog2(IMG_WORDS + 1);
  localparam int CNT_W   = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int GRP_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int SHIFT_W = LANES_PER_CYCLE * 8;

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(IMG_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_WORDS - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IMG,
    ARM,
    WAIT_WORD,
    COMPUTE,
    RESPOND,
    FINISH
  } state_t;

  state_t                    state;
  logic [PTR_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          word_cnt;
  logic [GRP_W-1:0]          grp_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic [15:0]               neuron_cnt;
  logic [DATA_W-1:0]         wt_reg;
  logic [DATA_W-1:0]         img_reg;
  logic                      done_pend;

  logic [DATA_W-1:0]         img_buf [IMG_WORDS];
  logic                      img_we;

  logic signed [16:0]        prod [LANES_PER_CYCLE];
  logic signed [ACC_W-1:0]   grp_sum;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   final_sum;

  // Once the pointer reaches the buffer depth, further words are dropped.
  // wr_ptr is always 0 in IDLE, so the first word lands at index 0.
  assign img_we = img_word_valid &&
                  ((state == IDLE) || ((state == LOAD_IMG) && (wr_ptr != PTR_FULL)));

  // Image buffer storage. Its contents are deliberately left without a reset.
  always_ff @(posedge clk) begin
    if (img_we) img_buf[wr_ptr] <= data_in;
  end

  // The operand registers shift down one lane group per compute cycle, so the
  // multipliers only ever look at the low lanes.
  for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
    logic [7:0] pix_b;
    logic [7:0] wt_b;
    assign pix_b   = img_reg[j*8 +: 8];
    assign wt_b    = wt_reg[j*8 +: 8];
    // Unsigned pixel times signed weight, both widened to 17 bits.
    assign prod[j] = $signed({9'b0, pix_b}) * $signed({{9{wt_b[7]}}, wt_b});
  end

  // Sum of this cycle's lane products, sign-extended to the accumulator width.
  always_comb begin
    grp_sum = '0;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      grp_sum = grp_sum + {{(ACC_W-17){prod[j][16]}}, prod[j]};
    end
  end

  assign acc_next = acc + grp_sum;

`ifdef MAC_DOT_ENGINE_RELU_EN
  assign final_sum = acc_next[ACC_W-1] ? '0 : acc_next;
`else
  assign final_sum = acc_next;
`endif

  assign busy = (state != IDLE) && (state != FINISH);

  // Control FSM with registered handshake pulses and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      word_cnt     <= '0;
      grp_cnt      <= '0;
      acc          <= '0;
      neuron_cnt   <= '0;
      wt_reg       <= '0;
      img_reg      <= '0;
      done_pend    <= 1'b0;
      next_img     <= 1'b0;
      mac_start    <= 1'b0;
      mac_done     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_index <= '0;
      img_overflow <= 1'b0;
    end else begin
      next_img     <= 1'b0;
      mac_start    <= 1'b0;
      mac_done     <= 1'b0;
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (img_word_valid) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            next_img <= 1'b1;
            state    <= LOAD_IMG;
          end
        end

        LOAD_IMG: begin
          if (img_word_valid) begin
            // The word is still acknowledged when dropped, so the reader keeps going.
            next_img <= 1'b1;
            if (wr_ptr == PTR_FULL) img_overflow <= 1'b1;
            else                    wr_ptr       <= wr_ptr + PTR_W'(1);
          end
          if (img_load_done) state <= ARM;
        end

        ARM: begin
          mac_start <= 1'b1;
          state     <= WAIT_WORD;
        end

        WAIT_WORD: begin
          if (all_done) begin
            state <= FINISH;
          end else if (wt_word_valid) begin
            wt_reg    <= data_in;
            img_reg   <= img_buf[word_cnt];
            grp_cnt   <= GRP_LAST;
            done_pend <= 1'b0;
            state     <= COMPUTE;
          end
        end

        COMPUTE: begin
          acc     <= acc_next;
          img_reg <= img_reg >> SHIFT_W;
          wt_reg  <= wt_reg >> SHIFT_W;
          // all_done here only takes effect after the word is answered.
          if (all_done) done_pend <= 1'b1;
          if (grp_cnt == '0) begin
            // mac_done and result are raised here so they are visible during RESPOND.
            mac_done <= 1'b1;
            state    <= RESPOND;
            if (word_cnt == CNT_LAST) begin
              result       <= final_sum;
              result_valid <= 1'b1;
              result_index <= neuron_cnt;
              acc          <= '0;
              word_cnt     <= '0;
              neuron_cnt   <= neuron_cnt + 16'd1;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end else begin
            grp_cnt <= grp_cnt - GRP_W'(1);
          end
        end

        RESPOND: begin
          if (done_pend || all_done) state <= FINISH;
          else                       state <= WAIT_WORD;
        end

        FINISH: begin
          state <= FINISH;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_dot_engine.md
Name: mac_dot_engine

Overview:
- Consumer stage directly downstream of the SDRAM reader.
- Image phase: captures the 128-bit image words the reader fetches into an internal image buffer, handshaking each word with next_img.
- Weight phase: requests the weight stream with mac_start, then multiply-accumulates each 128-bit weight word against the matching stored image word. Answers every word with mac_done and emits one dot-product result per neuron.

Parameters:
- DATA_W, 128, width of one reader word (16 byte lanes).
- IMG_WORDS, 49, image buffer depth in words (784 pixels / 16); also words per neuron.
- LANES_PER_CYCLE, 4, byte lanes multiplied per compute cycle; must divide 16.
- ACC_W, 32, signed accumulator/result width.

Ports:
- clk  in  1  single clock, shared with the reader's interface clock.
- reset  in  1  asynchronous, active-high.
- data_in  in  DATA_W  reader data register.
- img_word_valid  in  1  one-cycle strobe: data_in holds a new image word.
- img_load_done  in  1  level: reader finished the image (its READ_IMG_FIN indication).
- wt_word_valid  in  1  one-cycle strobe: data_in holds a new weight word.
- all_done  in  1  level: reader reached its final address.
- next_img  out  1  one-cycle pulse: image word stored, fetch next.
- mac_start  out  1  one-cycle pulse: begin weight stream.
- mac_done  out  1  one-cycle pulse: weight word consumed.
- result  out  ACC_W  last completed neuron dot product.
- result_valid  out  1  one-cycle pulse when result updates.
- result_index  out  16  neuron number of result, starting at 0.
- img_overflow  out  1  sticky: image word arrived with buffer full.
- busy  out  1  high in any state other than IDLE and FINISH.

Behaviour:
- Reset values: all outputs 0; state IDLE; image write pointer, word counter, lane counter, accumulator and neuron counter all 0. Buffer contents are not reset.
- States and transitions:
  - IDLE -> LOAD_IMG on the first img_word_valid. That word is stored at index 0.
  - LOAD_IMG: each img_word_valid writes data_in at wr_ptr, increments wr_ptr, and pulses next_img the following cycle.
    - If wr_ptr == IMG_WORDS, the word is dropped, img_overflow is set, and next_img still pulses so the reader does not stall.
    - img_load_done -> ARM.
  - ARM: pulse mac_start for 1 cycle -> WAIT_WORD.
  - WAIT_WORD:
    - wt_word_valid latches data_in into a weight register, reads the image word at word_cnt, and goes to COMPUTE.
    - all_done -> FINISH.
  - COMPUTE: runs 16/LANES_PER_CYCLE cycles. Each cycle it adds LANES_PER_CYCLE lane products to the accumulator. Lane k is bits [8k+7:8k].
  - RESPOND: pulse mac_done. Then:
    - If word_cnt == IMG_WORDS-1: result takes the final accumulator sum, result_valid pulses, result_index takes the neuron counter, the accumulator clears, word_cnt wraps to 0, and the neuron counter increments.
    - Otherwise word_cnt increments.
    - Next state is WAIT_WORD.
  - FINISH: terminal. Only reset leaves it.
- Arithmetic:
  - Pixel is an unsigned 8-bit value, zero-extended to 9 bits.
  - Weight is a signed 8-bit value.
  - Each product is 17 bits signed, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W. There is no saturation.
- Latency: wt_word_valid in cycle T gives mac_done in cycle T+1+16/LANES_PER_CYCLE (T+5 at default). result_valid coincides with mac_done on the last word of a neuron.
- Boundaries:
  - wt_word_valid in any state other than WAIT_WORD is ignored.
  - img_word_valid outside IDLE/LOAD_IMG is ignored.
  - all_done while in COMPUTE or RESPOND: the current word is finished, including mac_done and any result pulse, then the block goes to FINISH. A partial neuron produces no result.
  - img_load_done with fewer than IMG_WORDS words stored: proceed. Unwritten entries read as whatever they hold; the bench must not rely on them.
  - Reset asserted mid-operation returns everything to reset values within the same cycle, because reset is asynchronous.

Optional Feature:
- Macro: MAC_DOT_ENGINE_RELU_EN.
- Defined: a negative final neuron sum is replaced by 0 in result. The accumulator, result_valid and result_index are unaffected.
- Undefined: result is the raw signed sum.

Test Plan:
- Image load: 49 img_word_valid strobes, pixel bytes = word index, then img_load_done -> 49 next_img pulses, one mac_start pulse, img_overflow = 0.
- Overflow: 50 image strobes -> 50th word dropped, img_overflow = 1, next_img still pulses 50 times.
- Single neuron: all pixels 1, all weights 8'h02, 49 weight words -> 49 mac_done pulses, each 5 cycles after its strobe; result = 1568, result_valid on the 49th, result_index = 0.
- Signed weights: pixels 8'hFF, weights 8'h80 -> result = 49·16·255·(-128) = -25589760. With RELU_EN defined -> result = 0.
- Two neurons back-to-back: first all weights +1, second all -1, pixels 2 -> results 1568 then -1568, indices 0 and 1, accumulator cleared between them.
- all_done during the 3rd word of a neuron -> that word's mac_done still pulses, no result_valid, state FINISH, busy = 0. Reset mid-COMPUTE -> all outputs 0 immediately.
